fetch_pc_unit: RTL

//  Fetch-stage PC generator; sits directly downstream of the branch predictor.

---
 rtl/fetch_pc_unit.sv | 116 +++++++++++
 1 files changed

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - fetch-stage PC generator with valid/ready request port; BTB built only when FETCH_BTB_EN is defined
module fetch_pc_unit #(
   parameter int unsigned     XLEN        = 32,
   parameter logic [XLEN-1:0] RESET_PC    = '0,
   parameter int unsigned     BTB_ENTRIES = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            isBranchTakenPredicted,
   output logic            fetchValid,
   input  logic            fetchReady,
   output logic [XLEN-1:0] fetchPC,
   output logic            fetchPredTaken,
   output logic [XLEN-1:0] fetchPredTarget,
   input  logic            exRedirect,
   input  logic [XLEN-1:0] exRedirectPC,
   input  logic            exIsBranch,
   input  logic            exIsBranchTaken,
   input  logic [XLEN-1:0] exBranchPC,
   input  logic [XLEN-1:0] exBranchTarget
);

   localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

   typedef enum logic [1:0] {BOOT, RUN, BUBBLE} state_t;

   state_t          state, state_nxt;
   logic [XLEN-1:0] pc_q, pc_nxt;
   logic [XLEN-1:0] pc_plus4;
   logic            pred_taken;
   logic [XLEN-1:0] pred_target;

   assign pc_plus4 = pc_q + XLEN'(4);

`ifdef FETCH_BTB_EN
   localparam int unsigned IDX  = $clog2(BTB_ENTRIES);
   localparam int unsigned TAGW = XLEN - 2 - IDX;

   logic [BTB_ENTRIES-1:0] btb_valid;
   logic [TAGW-1:0]        btb_tag [BTB_ENTRIES];
   logic [XLEN-1:0]        btb_tgt [BTB_ENTRIES];
   logic [IDX-1:0]         rd_idx, wr_idx;
   logic                   btb_hit;
   logic                   btb_wr;
   logic                   unused_bits;

   assign rd_idx  = pc_q[2 +: IDX];
   assign wr_idx  = exBranchPC[2 +: IDX];
   assign btb_wr  = exIsBranch && exIsBranchTaken;
   assign btb_hit = btb_valid[rd_idx] && (btb_tag[rd_idx] == pc_q[XLEN-1 -: TAGW]);

   assign pred_taken  = btb_hit && isBranchTakenPredicted;
   assign pred_target = pred_taken ? btb_tgt[rd_idx] : pc_plus4;
   assign unused_bits = ^exBranchPC[1:0];

   // valid bits: cleared by reset, set by taken resolutions only
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         btb_valid <= '0;
      else if (btb_wr)
         btb_valid[wr_idx] <= 1'b1;
   end

   // tag/target payload; meaningless while the valid bit is clear, so no reset
   always_ff @(posedge clk) begin
      if (btb_wr) begin
         btb_tag[wr_idx] <= exBranchPC[XLEN-1 -: TAGW];
         btb_tgt[wr_idx] <= exBranchTarget;
      end
   end
`else
   logic unused_inputs;

   assign pred_taken    = 1'b0;
   assign pred_target   = pc_plus4;
   assign unused_inputs = ^{isBranchTakenPredicted, exIsBranch, exIsBranchTaken,
                            exBranchPC, exBranchTarget};
`endif

   assign fetchPC         = pc_q;
   assign fetchPredTaken  = pred_taken;
   assign fetchPredTarget = pred_target;

   // FSM state and fetch PC registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= BOOT;
         pc_q  <= RESET_PC;
      end else begin
         state <= state_nxt;
         pc_q  <= pc_nxt;
      end
   end

   // next state and next PC; a redirect overrides accept and stall in every state
   always_comb begin
      state_nxt  = state;
      pc_nxt     = pc_q;
      fetchValid = 1'b0;
      case (state)
         BOOT:   state_nxt = RUN;
         RUN: begin
            fetchValid = 1'b1;
            if (fetchReady)
               pc_nxt = pred_target;
         end
         BUBBLE: state_nxt = RUN;
         default: state_nxt = BOOT;
      endcase
      if (exRedirect) begin
         state_nxt = BUBBLE;
         pc_nxt    = exRedirectPC & ALIGN_MASK;
      end
   end

endmodule
